// File: rtl/teclado_pkg.sv
// Shared types and constants for the 4x4 keypad encoder.
//   KEY_W   : width of an encoded key (code = 4*row + col)
//   N_ROWS  : keypad rows
//   N_COLS  : keypad columns
//   estado_t: debounce FSM states
//   clase_t : classification of one complete scan frame
package teclado_pkg;
    localparam int KEY_W  = 4;
    localparam int N_ROWS = 4;
    localparam int N_COLS = 4;

    typedef enum logic [1:0] {
        IDLE,
        CONFIRM,
        PRESSED,
        RELEASING
    } estado_t;

    typedef enum logic [1:0] {
        NONE,
        SINGLE,
        MULTI
    } clase_t;
endpackage

// File: rtl/barrido_teclado.sv
// Column scanner for the 4x4 keypad.
//   clk, rst   : system clock, synchronous active-high reset
//   filas      : keypad rows, active-low, asynchronous
//   columnas   : column drive, active-low, one column low per SCAN_DIV-cycle slot
//   snapshot   : complete frame image, bit 4*r+c set when row r seen with column c
//   frame_done : one-cycle pulse in the last cycle of column 3
module barrido_teclado
    import teclado_pkg::*;
#(
    parameter int SCAN_DIV = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_ROWS-1:0]          filas,
    output logic [N_COLS-1:0]          columnas,
    output logic [N_ROWS*N_COLS-1:0]   snapshot,
    output logic                       frame_done
);
    localparam int SLOT_W = $clog2(SCAN_DIV);

    logic [SLOT_W-1:0]        slot;
    logic [1:0]               col;
    logic [N_ROWS-1:0]        sync1, sync2;
    logic [N_ROWS-1:0]        row_s;
    logic [N_ROWS*N_COLS-1:0] snap_q;
    logic                     slot_end;

    assign row_s      = ~sync2;
    assign slot_end   = (slot == SLOT_W'(SCAN_DIV - 1));
    assign frame_done = slot_end && (col == 2'd3);
    assign columnas   = ~(N_COLS'(1) << col);

    // The snapshot output already contains the sample taken in this cycle,
    // so the classifier sees all four columns at frame_done without an
    // extra cycle of delay. The register itself restarts empty each frame.
    always_comb begin
        snapshot = snap_q;
        if (slot_end) begin
            for (int unsigned r = 0; r < N_ROWS; r++) begin
                snapshot[r*N_COLS + 32'(col)] = row_s[r];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            slot   <= '0;
            col    <= '0;
            sync1  <= '1;
            sync2  <= '1;
            snap_q <= '0;
        end else begin
            sync1 <= filas;
            sync2 <= sync1;
            if (slot_end) begin
                slot <= '0;
                col  <= col + 2'd1;
            end else begin
                slot <= slot + SLOT_W'(1);
            end
            snap_q <= frame_done ? '0 : snapshot;
        end
    end
endmodule

// File: rtl/codificador_teclado.sv
// 4x4 matrix keypad encoder with debounce.
//   clk, rst : system clock, synchronous active-high reset
//   filas    : keypad rows, active-low, asynchronous
//   columnas : column drive, active-low, exactly one bit low
//   out      : code of the last accepted key (4*row + col)
//   valid    : one-cycle pulse when a new press is accepted
//   held     : high while the accepted key is considered pressed
module codificador_teclado
    import teclado_pkg::*;
#(
    parameter int SCAN_DIV     = 4,
    parameter int DEBOUNCE_CNT = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_ROWS-1:0] filas,
    output logic [N_COLS-1:0] columnas,
    output logic [KEY_W-1:0]  out,
    output logic              valid,
    output logic              held
);
    localparam logic [3:0] DEB = 4'(DEBOUNCE_CNT);

    logic [N_ROWS*N_COLS-1:0] snapshot;
    logic                     frame_done;

    barrido_teclado #(.SCAN_DIV(SCAN_DIV)) u_barrido (
        .clk        (clk),
        .rst        (rst),
        .filas      (filas),
        .columnas   (columnas),
        .snapshot   (snapshot),
        .frame_done (frame_done)
    );

    // Frame classifier
    logic [4:0]       n_set;
    logic [KEY_W-1:0] key;
    clase_t           clase;

    always_comb begin
        n_set = '0;
        key   = '0;
        for (int unsigned i = 0; i < N_ROWS*N_COLS; i++) begin
            if (snapshot[i]) begin
                n_set = n_set + 5'd1;
                key   = KEY_W'(i);
            end
        end
        if (n_set == 5'd0)      clase = NONE;
        else if (n_set == 5'd1) clase = SINGLE;
        else                    clase = MULTI;
    end

    // Debounce FSM and output registers
    estado_t          estado, estado_n;
    logic [KEY_W-1:0] cand, cand_n;
    logic [3:0]       cnt, cnt_n, cnt_inc;
    logic [KEY_W-1:0] out_q, out_n;
    logic             held_q, held_n;
    logic             valid_q, valid_n;

    assign cnt_inc = cnt + 4'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            estado  <= IDLE;
            cand    <= '0;
            cnt     <= '0;
            out_q   <= '0;
            held_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            estado  <= estado_n;
            cand    <= cand_n;
            cnt     <= cnt_n;
            out_q   <= out_n;
            held_q  <= held_n;
            valid_q <= valid_n;
        end
    end

    always_comb begin
        estado_n = estado;
        cand_n   = cand;
        cnt_n    = cnt;
        out_n    = out_q;
        held_n   = held_q;
        valid_n  = 1'b0;
        if (frame_done) begin
            unique case (estado)
                IDLE: begin
                    if (clase == SINGLE) begin
                        cand_n   = key;
                        cnt_n    = 4'd1;
                        estado_n = CONFIRM;
                    end
                end
                CONFIRM: begin
                    if (clase == SINGLE && key == cand) begin
                        cnt_n = cnt_inc;
                        if (cnt_inc == DEB) begin
                            estado_n = PRESSED;
                            out_n    = cand;
                            valid_n  = 1'b1;
                            held_n   = 1'b1;
                        end
                    end else if (clase == SINGLE) begin
                        cand_n = key;
                        cnt_n  = 4'd1;
                    end else begin
                        estado_n = IDLE;
                    end
                end
                PRESSED: begin
                    if (clase == NONE) begin
                        cnt_n    = 4'd1;
                        estado_n = RELEASING;
                    end
                end
                RELEASING: begin
                    if (clase == NONE) begin
                        cnt_n = cnt_inc;
                        if (cnt_inc == DEB) begin
                            estado_n = IDLE;
                            held_n   = 1'b0;
                        end
                    end else begin
                        estado_n = PRESSED;
                    end
                end
                default: estado_n = IDLE;
            endcase
        end
    end

    assign out   = out_q;
    assign held  = held_q;
    assign valid = valid_q;
endmodule

// File: tb/tb_codificador_teclado.sv
// Self-checking bench for codificador_teclado: a keypad model drives the
// rows from the set of pressed keys, and a frame-level reference model
// predicts out/valid/held/columnas every cycle.
module tb_codificador_teclado;
    localparam int SCAN_DIV = 4;
    localparam int DEB      = 3;
    localparam int FRAME    = 4 * SCAN_DIV;

    logic        clk;
    logic        rst;
    logic [3:0]  filas;
    logic [3:0]  columnas;
    logic [3:0]  out;
    logic        valid;
    logic        held;
    logic [15:0] pressed;

    int n_tests = 0;
    int n_fail  = 0;
    int nvalid  = 0;
    bit chk_en  = 0;

    codificador_teclado #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE_CNT(DEB)) dut (
        .clk      (clk),
        .rst      (rst),
        .filas    (filas),
        .columnas (columnas),
        .out      (out),
        .valid    (valid),
        .held     (held)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Physical keypad: a pressed key shorts its row to its column.
    function automatic logic [3:0] keypad(input logic [15:0] p, input logic [3:0] cols);
        logic [3:0] f;
        f = '1;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (p[4*r+c] && !cols[c]) f[r] = 1'b0;
        return f;
    endfunction

    assign filas = keypad(pressed, columnas);

    // Frame-level reference: runs of identical frames accept a key or a release.
    typedef struct packed {
        logic       held;
        logic [3:0] out;
        logic       valid;
        logic [3:0] run_key;
        int         run_len;
        int         none_run;
    } mdl_t;

    mdl_t m;
    int   cyc;

    function automatic mdl_t frame_step(input mdl_t s, input logic [15:0] mask);
        mdl_t n;
        int   ones;
        int   k;
        n     = s;
        ones  = $countones(mask);
        k     = 0;
        n.valid = 1'b0;
        for (int i = 0; i < 16; i++) if (mask[i]) k = i;
        if (!s.held) begin
            if (ones == 1) begin
                n.run_len = (s.run_len > 0 && int'(s.run_key) == k) ? s.run_len + 1 : 1;
                n.run_key = 4'(k);
                if (n.run_len == DEB) begin
                    n.held     = 1'b1;
                    n.out      = 4'(k);
                    n.valid    = 1'b1;
                    n.run_len  = 0;
                    n.none_run = 0;
                end
            end else begin
                n.run_len = 0;
            end
        end else begin
            if (ones == 0) begin
                n.none_run = s.none_run + 1;
                if (n.none_run == DEB) begin
                    n.held     = 1'b0;
                    n.none_run = 0;
                    n.run_len  = 0;
                end
            end else begin
                n.none_run = 0;
            end
        end
        return n;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m   <= '0;
            cyc <= 0;
        end else if (cyc == FRAME - 1) begin
            cyc <= 0;
            m   <= frame_step(m, pressed);
        end else begin
            cyc     <= cyc + 1;
            m.valid <= 1'b0;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    logic [3:0] exp_cols;
    always @(negedge clk) begin
        if (chk_en) begin
            exp_cols = ~(4'b0001 << (cyc / SCAN_DIV));
            chk("columnas", int'(columnas), int'(exp_cols));
            chk("out",      int'(out),      int'(m.out));
            chk("valid",    int'(valid),    int'(m.valid));
            chk("held",     int'(held),     int'(m.held));
            if (valid === 1'b1) nvalid++;
        end
    end

    task automatic run_frame(input logic [15:0] msk);
        pressed = msk;
        repeat (FRAME) @(negedge clk);
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        rst = 1'b1;
        repeat (n) @(negedge clk);
        rst = 1'b0;
    endtask

    int base;

    initial begin
        rst     = 1'b1;
        pressed = '0;
        @(negedge clk);
        chk_en = 1;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Reset values and column stepping
        #1;
        chk("rst_columnas", int'(columnas), 4'b1110);
        chk("rst_out",      int'(out),      0);
        chk("rst_valid",    int'(valid),    0);
        chk("rst_held",     int'(held),     0);
        repeat (4) @(negedge clk);
        #1 chk("col_c4", int'(columnas), 4'b1101);
        repeat (4) @(negedge clk);
        #1 chk("col_c8", int'(columnas), 4'b1011);
        repeat (4) @(negedge clk);
        #1 chk("col_c12", int'(columnas), 4'b0111);
        repeat (4) @(negedge clk);

        // Clean press of row1/col2 for 10 frames
        base = nvalid;
        repeat (2) run_frame(16'h0040);
        #1 chk("press_no_early_valid", nvalid - base, 0);
        run_frame(16'h0040);
        #1;
        chk("press_valid_pulse", int'(valid), 1);
        chk("press_out", int'(out), 6);
        chk("press_held", int'(held), 1);
        repeat (7) run_frame(16'h0040);
        #1;
        chk("press_one_valid", nvalid - base, 1);
        chk("press_still_held", int'(held), 1);

        // Release debounce with a one-frame re-press
        run_frame(16'h0000);
        run_frame(16'h0040);
        run_frame(16'h0000);
        run_frame(16'h0000);
        #1 chk("release_held_2none", int'(held), 1);
        run_frame(16'h0000);
        #1;
        chk("release_held_3none", int'(held), 0);
        chk("release_no_second_valid", nvalid - base, 1);

        // Bounce on row3/col3
        base = nvalid;
        for (int i = 0; i < 4; i++) begin
            run_frame(16'h8000);
            run_frame(16'h0000);
        end
        #1;
        chk("bounce_no_valid", nvalid - base, 0);
        chk("bounce_out", int'(out), 6);
        chk("bounce_held", int'(held), 0);

        // Two keys together, then key 5 released
        base = nvalid;
        repeat (5) run_frame(16'h0021);
        #1 chk("multi_no_valid", nvalid - base, 0);
        repeat (3) run_frame(16'h0001);
        #1;
        chk("multi_then_single_valid", int'(valid), 1);
        chk("multi_then_single_out", int'(out), 0);
        repeat (3) run_frame(16'h0000);

        // Press key 12 so the following reset has a visible effect on out
        repeat (3) run_frame(16'h1000);
        #1 chk("key12_out", int'(out), 12);
        repeat (3) run_frame(16'h0000);

        // Reset in the middle of confirming key 9
        base = nvalid;
        run_frame(16'h0200);
        repeat (6) @(negedge clk);
        do_reset(3);
        #1;
        chk("midrst_out", int'(out), 0);
        chk("midrst_held", int'(held), 0);
        chk("midrst_valid", int'(valid), 0);
        chk("midrst_columnas", int'(columnas), 4'b1110);
        repeat (2) run_frame(16'h0200);
        #1 chk("midrst_no_early_valid", nvalid - base, 0);
        run_frame(16'h0200);
        #1;
        chk("midrst_valid_after3", int'(valid), 1);
        chk("midrst_out9", int'(out), 9);
        repeat (3) run_frame(16'h0000);

        // Randomized segments of none / single / multi frames
        for (int s = 0; s < 80; s++) begin
            int          kind;
            int          len;
            logic [15:0] msk;
            kind = int'($urandom_range(0, 3));
            len  = int'($urandom_range(1, 5));
            msk  = '0;
            case (kind)
                1, 2:    msk = 16'(1) << $urandom_range(0, 15);
                3:       msk = (16'(1) << $urandom_range(0, 15)) | (16'(1) << $urandom_range(0, 15));
                default: msk = '0;
            endcase
            repeat (len) run_frame(msk);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/codificador_teclado.md
Name: codificador_teclado

Overview:
- Scans a 4x4 matrix keypad and encodes the single pressed key into a 4-bit code on `out[3:0]`, with a one-cycle `valid` strobe.
- Input-side counterpart of the 4-bit-code-to-segments decoder in the game datapath: it produces the nibble codes that the display and game logic consume.
- Contains column scanning, row synchronisation, snapshot building and a debounce FSM.

Parameters:
- SCAN_DIV, 4: clock cycles each column is driven. Legal values are 4 or more.
- DEBOUNCE_CNT, 3: consecutive identical scan frames needed to accept a press or a release. Legal values are 2 to 15.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous reset, active-high
- filas  input  4  keypad rows, active-low (externally pulled up), asynchronous
- columnas  output  4  column drive, active-low, exactly one bit low at any time
- out  output  4  code of the last accepted key: code = 4*row + col
- valid  output  1  one-cycle pulse when a new press is accepted
- held  output  1  high while the accepted key is considered pressed

Behaviour:
- Reset values: `columnas`=4'b1110, `out`=0, `valid`=0, `held`=0, FSM in IDLE, all counters and snapshot bits 0.
- Reset asserted mid-scan or mid-debounce aborts immediately to these values.
- Row synchronisation: `filas` passes through a 2-flop synchroniser and is inverted to active-high as `row_s`.
- Scan timing:
  - Column c (0..3) is driven low for SCAN_DIV cycles; column order is 0,1,2,3,0, and so on.
  - `row_s` is sampled in the last cycle of each column slot into snapshot bits [4*r+c].
  - A frame is 4*SCAN_DIV cycles. `frame_done` pulses in the last cycle of column 3.
- Frame classification, done at `frame_done`:
  - NONE: zero snapshot bits set.
  - SINGLE(k): exactly one bit k set.
  - MULTI: two or more bits set. MULTI is treated as NONE for press detection and as "not released" in PRESSED and RELEASING.
- The snapshot clears at the start of each frame.
- The FSM evaluates only on `frame_done`. `cnt` is 4 bits.
  - IDLE: on SINGLE(k), set cand=k, cnt=1, go to CONFIRM. Otherwise stay.
  - CONFIRM:
    - SINGLE(cand): cnt+1. When cnt reaches DEBOUNCE_CNT, go to PRESSED, set out=cand, pulse `valid` for 1 cycle, set held=1.
    - SINGLE(j), j different from cand: restart with cand=j, cnt=1.
    - NONE or MULTI: go to IDLE.
  - PRESSED: on NONE, set cnt=1 and go to RELEASING. SINGLE or MULTI of any key stays; no new event is produced until release.
  - RELEASING:
    - NONE: cnt+1. When cnt reaches DEBOUNCE_CNT, go to IDLE and set held=0.
    - Any key: return to PRESSED; `out` is unchanged.
- Output timing:
  - `valid` asserts in the cycle after the accepting `frame_done` and is registered.
  - `out` and `held` update in that same cycle.
  - `out` holds its value until the next accepted press.
- Latency: a press that is stable from a frame boundary is accepted DEBOUNCE_CNT frames later.
- Boundary cases:
  - A bounce shorter than one frame cannot produce `valid`.
  - A key held indefinitely produces exactly one `valid`.
  - Pressing a second key while the first is held produces no event.

Decomposition:
- Shared package `teclado_pkg`:
  - FSM state enum: IDLE, CONFIRM, PRESSED, RELEASING.
  - Constants KEY_W=4, N_ROWS=4, N_COLS=4.
  - Frame class enum: NONE, SINGLE, MULTI.
- Sub-module `barrido_teclado`:
  - Contains the column counter and slot counter, the 2-flop synchroniser and the snapshot register.
  - Outputs `columnas`, `snapshot[15:0]` and `frame_done`.
- The top level holds the classifier, the FSM and the output registers.

Test Plan:
- Reset: hold `rst` 3 cycles. Expect `columnas`=1110, `out`=0, `valid`=0, `held`=0; after release, `columnas` steps 1101 at cycle 4, 1011 at 8, 0111 at 12 (SCAN_DIV=4).
- Clean press: key row1/col2 (row 1 pulled low while column 2 is driven), held 10 frames, DEBOUNCE_CNT=3. Expect `out`=4'd6, exactly one `valid` pulse 3 frames after the first full frame containing the key, and `held`=1.
- Bounce: key row3/col3 toggled on 1-frame/off 1-frame for 8 frames. Expect no `valid`, `out` unchanged, `held`=0.
- Release debounce: after the press of 6, release for 1 frame, press again for 1 frame, then release 3 frames. Expect no second `valid`; `held` falls after the final 3 NONE frames.
- Multi-key: keys 0 and 5 together for 5 frames. Expect no `valid`. Then release key 5 with key 0 still held. Expect `valid` with `out`=0 after 3 frames.
- Reset mid-CONFIRM: assert `rst` during frame 2 of a press of key 9. Expect outputs back to reset values; after deassert, `valid` for key 9 only after 3 more full frames.
